// File: rtl/skid_buffer.sv
// Two-entry AXI-Stream register slice. Every output (o_valid, o_ready, o_data)
// comes straight from a flop, so no combinational path crosses the slice.
// Beats are kept in order in an output register and a skid register.
module skid_buffer #(
  parameter int DWIDTH = 8
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              i_valid,
  input  logic [DWIDTH-1:0] i_data,
  output logic              o_ready,
  output logic              o_valid,
  output logic [DWIDTH-1:0] o_data,
  input  logic              i_ready
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t              state_r;
  state_t              state_nxt_s;
  logic [DWIDTH-1:0]   data_r;
  logic [DWIDTH-1:0]   data_nxt_s;
  logic [DWIDTH-1:0]   skid_r;
  logic [DWIDTH-1:0]   skid_nxt_s;
  logic                valid_r;
  logic                valid_nxt_s;
  logic                ready_r;
  logic                ready_nxt_s;
  logic                ins_s;
  logic                outs_s;

  // Handshakes are qualified only by registered outputs.
  assign ins_s  = i_valid & ready_r;
  assign outs_s = valid_r & i_ready;

  // Next-state, next-storage and next-output computation.
  always_comb begin
    state_nxt_s = state_r;
    data_nxt_s  = data_r;
    skid_nxt_s  = skid_r;
    case (state_r)
      ST_EMPTY: begin
        if (ins_s) begin
          state_nxt_s = ST_BUSY;
          data_nxt_s  = i_data;
        end else begin
          state_nxt_s = ST_EMPTY;
        end
      end
      ST_BUSY: begin
        if (ins_s && !outs_s) begin
          // Sink stalled: park the new beat behind the one on display.
          state_nxt_s = ST_FULL;
          skid_nxt_s  = i_data;
        end else if (ins_s && outs_s) begin
          // Pass-through: occupancy unchanged.
          state_nxt_s = ST_BUSY;
          data_nxt_s  = i_data;
        end else if (outs_s) begin
          state_nxt_s = ST_EMPTY;
        end else begin
          state_nxt_s = ST_BUSY;
        end
      end
      ST_FULL: begin
        if (outs_s) begin
          state_nxt_s = ST_BUSY;
          data_nxt_s  = skid_r;
        end else begin
          state_nxt_s = ST_FULL;
        end
      end
      default: begin
        state_nxt_s = ST_EMPTY;
      end
    endcase
    // Outputs are decoded from the next state so they can be registered.
    valid_nxt_s = (state_nxt_s != ST_EMPTY);
    ready_nxt_s = (state_nxt_s != ST_FULL);
  end

  // State, storage and output registers; reset discards any buffered beats.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r <= ST_EMPTY;
      data_r  <= {DWIDTH{1'b0}};
      skid_r  <= {DWIDTH{1'b0}};
      valid_r <= 1'b0;
      ready_r <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      data_r  <= data_nxt_s;
      skid_r  <= skid_nxt_s;
      valid_r <= valid_nxt_s;
      ready_r <= ready_nxt_s;
    end
  end

  assign o_ready = ready_r;
  assign o_valid = valid_r;
  assign o_data  = data_r;

endmodule

// File: tb/tb_skid_buffer.sv
// Directed and random stimulus for skid_buffer with an in-order scoreboard:
// accepted beats are queued, delivered beats are popped and compared.
module tb_skid_buffer;

  logic       clk = 1'b0;
  logic       rstn = 1'b1;
  logic       i_valid = 1'b0;
  logic [7:0] i_data = 8'd0;
  logic       i_ready = 1'b0;
  logic       o_ready;
  logic       o_valid;
  logic [7:0] o_data;

  int         total = 0;
  int         bad = 0;
  logic [7:0] sb_q[$];
  logic [7:0] src_cnt;
  logic       acc;

  skid_buffer #(.DWIDTH(8)) dut (
    .clk     (clk),
    .rstn    (rstn),
    .i_valid (i_valid),
    .i_data  (i_data),
    .o_ready (o_ready),
    .o_valid (o_valid),
    .o_data  (o_data),
    .i_ready (i_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at posedge+1: drive, evaluate handshakes at the negedge, return at posedge+1.
  task automatic cycle(input logic v, input logic [7:0] d, input logic r, output logic accepted);
    logic [7:0] exp_d;
    i_valid = v;
    i_data  = d;
    i_ready = r;
    @(negedge clk);
    accepted = i_valid & o_ready;
    if (o_valid & i_ready) begin
      if (sb_q.size() == 0) begin
        check("sb_unexpected_beat", 32'd1, 32'd0);
      end else begin
        exp_d = sb_q.pop_front();
        check("sb_data", 32'(o_data), 32'(exp_d));
      end
    end
    if (accepted) sb_q.push_back(i_data);
    @(posedge clk);
    #1;
  endtask

  initial begin
    // 1. asynchronous reset mid-clock
    @(posedge clk);
    #3;
    rstn = 1'b0;
    #1;
    check("rst_valid", 32'(o_valid), 32'd0);
    check("rst_data",  32'(o_data),  32'd0);
    check("rst_ready", 32'(o_ready), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    #1;
    check("ready_before_edge", 32'(o_ready), 32'd0);
    @(posedge clk);
    #1;
    check("ready_after_edge", 32'(o_ready), 32'd1);
    check("valid_after_rst",  32'(o_valid), 32'd0);

    // 2. streaming with sink always ready
    cycle(1'b1, 8'd1, 1'b1, acc);
    check("stream_lat_valid", 32'(o_valid), 32'd1);
    check("stream_lat_data",  32'(o_data),  32'd1);
    cycle(1'b1, 8'd2, 1'b1, acc);
    check("stream_ready", 32'(o_ready), 32'd1);
    cycle(1'b1, 8'd3, 1'b1, acc);
    cycle(1'b1, 8'd4, 1'b1, acc);
    check("stream_valid", 32'(o_valid), 32'd1);
    check("stream_data4", 32'(o_data),  32'd4);
    cycle(1'b0, 8'd0, 1'b1, acc);
    check("stream_drained", 32'(o_valid), 32'd0);

    // 3. fill to FULL with sink stalled, then drain
    cycle(1'b1, 8'd1, 1'b0, acc);
    cycle(1'b1, 8'd2, 1'b0, acc);
    check("full_data",  32'(o_data),  32'd1);
    check("full_valid", 32'(o_valid), 32'd1);
    check("full_ready", 32'(o_ready), 32'd0);
    cycle(1'b1, 8'd3, 1'b0, acc);
    check("full_no_accept", 32'(acc), 32'd0);
    cycle(1'b0, 8'd0, 1'b1, acc);
    check("drain1_ready", 32'(o_ready), 32'd1);
    check("drain1_data",  32'(o_data),  32'd2);
    cycle(1'b0, 8'd0, 1'b1, acc);
    check("drain2_empty", 32'(o_valid), 32'd0);

    // 4. FULL with a single-cycle ready pulse
    cycle(1'b1, 8'd5, 1'b0, acc);
    cycle(1'b1, 8'd6, 1'b0, acc);
    check("pulse_full_ready", 32'(o_ready), 32'd0);
    cycle(1'b0, 8'd0, 1'b1, acc);
    check("pulse_ready", 32'(o_ready), 32'd1);
    check("pulse_valid", 32'(o_valid), 32'd1);
    check("pulse_data",  32'(o_data),  32'd6);
    cycle(1'b0, 8'd0, 1'b0, acc);
    check("pulse_hold_data", 32'(o_data), 32'd6);
    cycle(1'b0, 8'd0, 1'b1, acc);
    check("pulse_empty", 32'(o_valid), 32'd0);

    // 5. random valid/ready, incrementing source
    src_cnt = 8'd1;
    for (int i = 0; i < 100; i++) begin
      cycle(1'($urandom_range(0, 1)), src_cnt, 1'($urandom_range(0, 1)), acc);
      if (acc) src_cnt = src_cnt + 8'd1;
    end
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 8'd0, 1'b1, acc);
    end
    check("rand_sb_empty", 32'(sb_q.size()), 32'd0);
    check("rand_drained",  32'(o_valid),     32'd0);

    // 6. reset while FULL discards buffered beats
    cycle(1'b1, 8'd7, 1'b0, acc);
    cycle(1'b1, 8'd8, 1'b0, acc);
    check("pre_rst_full", 32'(o_ready), 32'd0);
    #2;
    rstn = 1'b0;
    #1;
    check("rst_full_valid", 32'(o_valid), 32'd0);
    check("rst_full_ready", 32'(o_ready), 32'd0);
    check("rst_full_data",  32'(o_data),  32'd0);
    sb_q.delete();
    @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;
    check("rst2_ready", 32'(o_ready), 32'd1);
    check("rst2_valid", 32'(o_valid), 32'd0);
    cycle(1'b1, 8'd9, 1'b1, acc);
    check("post_rst_data", 32'(o_data), 32'd9);
    cycle(1'b0, 8'd0, 1'b1, acc);
    check("post_rst_empty", 32'(o_valid),     32'd0);
    check("post_rst_sb",    32'(sb_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
